// File: rtl/cl_stream_pkg.sv
// Shared types for the cache-line stream reader: line/address types and FSM states.
package cl_stream_pkg;

    localparam int CL_BYTES    = 64;
    localparam int CL_IDX_BITS = 6;

    typedef logic [511:0] t_cl_data;
    typedef logic [63:0]  t_byte_addr;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } t_rd_state;

endpackage

// File: rtl/cl_line_fifo.sv
// First-word-fall-through line buffer; a pop in the same cycle frees a slot for a push when full.
module cl_line_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH[CW-1:0]);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cl_stream_reader.sv
// Fetches num_lines consecutive cache lines from host memory and streams them out in order,
// issuing reads only when the line buffer has a guaranteed slot for the response.
module cl_stream_reader
    import cl_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      base_addr,
    input  logic [CNT_W-1:0] num_lines,
    input  logic             rd_available,
    output logic [63:0]      rd_addr,
    output logic             req_rd,
    input  logic             rd_valid,
    input  logic [511:0]     rd_data,
    output logic             out_valid,
    output logic [511:0]     out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int OW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OW:0] DEPTH_C = FIFO_DEPTH[OW:0];

    t_rd_state        state_q;
    t_byte_addr       base_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] popped_q;
    logic [OW-1:0]    outstanding_q;
    t_byte_addr       rd_addr_q;
    logic             req_rd_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic [OW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OW:0]      credit_used;
    logic             fire;
    logic             accept;
    logic             stray;
    logic             pop;

    // Credit uses registered values only, so a pop this cycle frees a slot next cycle.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign fire   = (state_q == RUN) && (issued_q < num_q) && rd_available
                    && (credit_used < DEPTH_C);
    assign accept = rd_valid && (state_q != IDLE) && (outstanding_q != '0);
    assign stray  = rd_valid && !accept;
    assign pop    = !fifo_empty && out_ready;

    cl_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(t_cl_data))
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept),
        .push_data_i (rd_data),
        .pop_i       (pop),
        .head_o      (out_data),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            base_q        <= '0;
            num_q         <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            outstanding_q <= '0;
            rd_addr_q     <= '0;
            req_rd_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            req_rd_q <= fire;
            busy_q   <= (state_q == RUN) || (state_q == DRAIN);
            done_q   <= (state_q == DONE);

            if (fire) begin
                rd_addr_q <= base_q + t_byte_addr'({issued_q, {CL_IDX_BITS{1'b0}}});
                issued_q  <= issued_q + CNT_W'(1);
            end

            case ({fire, accept})
                2'b10:   outstanding_q <= outstanding_q + OW'(1);
                2'b01:   outstanding_q <= outstanding_q - OW'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            if (pop) popped_q <= popped_q + CNT_W'(1);

            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q        <= base_addr & ~t_byte_addr'(CL_BYTES - 1);
                        num_q         <= num_lines;
                        issued_q      <= '0;
                        popped_q      <= '0;
                        outstanding_q <= '0;
                        error_q       <= 1'b0;
                        state_q       <= (num_lines == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (issued_q == num_q) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (popped_q == num_q) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase

            if (stray) error_q <= 1'b1;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign req_rd    = req_rd_q;
    assign out_valid = !fifo_empty;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

    assert property (@(posedge clk) disable iff (reset) !(accept && fifo_full && !pop))
        else $error("cl_stream_reader: line buffer overflow");

endmodule

// File: tb/tb_cl_stream_reader.sv
// Directed bench: a memory responder plus an in-order line model checked every cycle.
module tb_cl_stream_reader;
    import cl_stream_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          reset, start, rd_available, req_rd, rd_valid;
    logic          out_valid, out_ready, busy, done, error;
    logic [63:0]   base_addr, rd_addr;
    logic [CW-1:0] num_lines;
    logic [511:0]  rd_data, out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    cl_stream_reader #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_lines(num_lines), .rd_available(rd_available), .rd_addr(rd_addr),
        .req_rd(req_rd), .rd_valid(rd_valid), .rd_data(rd_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {int due; logic [63:0] addr;} resp_t;
    resp_t       rq[$];
    int          lat = 3;
    logic        toggle_avail = 1'b0;
    logic        inject = 1'b0;

    logic [63:0] m_base;
    int          m_num, m_issued, m_popped;
    t_cl_data    m_exp[$];
    logic        prev_avail = 1'b0;
    int          done_seen, done_cyc, outv_cycles;
    logic        busy_at_done;
    logic [63:0] addr_log[$];
    int          req_cyc[$];
    t_cl_data    first_data;

    function automatic t_cl_data pat(input logic [63:0] a);
        t_cl_data d;
        for (int j = 0; j < 8; j++) d[j*64 +: 64] = a + 64'(j) * 64'h0000_0001_0000_0001;
        return d;
    endfunction

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory: answers each request lat cycles later, in order.
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            resp_t r;
            @(posedge clk);
            #2;
            if (toggle_avail) rd_available = !rd_available;
            rd_valid = 1'b0;
            if (inject) begin
                rd_valid = 1'b1;
                rd_data  = '1;
                inject   = 1'b0;
            end else if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                rd_valid = 1'b1;
                rd_data  = pat(r.addr);
            end
        end
    end

    // Compare process: model of the expected request and line streams.
    initial begin
        forever begin
            t_cl_data e;
            @(negedge clk);
            if (req_rd) begin
                chk64("req_addr", rd_addr, m_base + 64'(m_issued) * 64);
                chki("req_after_avail", int'(prev_avail), 1);
                m_issued++;
                chki("req_within_num", int'(m_issued <= m_num), 1);
                chki("req_credit", int'(m_issued - m_popped <= DEPTH), 1);
                addr_log.push_back(rd_addr);
                req_cyc.push_back(cyc);
                rq.push_back('{cyc + lat, rd_addr});
            end
            if (out_valid) outv_cycles++;
            if (out_valid && out_ready) begin
                checks++;
                if (m_exp.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra: line 0x%0h with none expected", out_data[63:0]);
                end else begin
                    e = m_exp.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL out_data: got lane0 0x%0h, expected lane0 0x%0h",
                                 out_data[63:0], e[63:0]);
                    end
                end
                if (m_popped == 0) first_data = out_data;
                m_popped++;
            end
            if (done) begin
                done_seen++;
                done_cyc     = cyc;
                busy_at_done = busy;
                chki("done_all_popped", m_popped, m_num);
            end
            prev_avail = rd_available;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [63:0] b, input int n, output int s);
        start     = 1'b1;
        base_addr = b;
        num_lines = CW'(n);
        m_base    = b & ~64'h3F;
        m_num     = n;
        m_issued  = 0;
        m_popped  = 0;
        m_exp.delete();
        addr_log.delete();
        req_cyc.delete();
        done_seen   = 0;
        outv_cycles = 0;
        for (int i = 0; i < n; i++) m_exp.push_back(pat(m_base + 64'(i) * 64));
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done_seen == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_seen == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
        repeat (3) tick();
    endtask

    initial begin
        int s, k;
        logic [63:0] exp1 [4];
        exp1[0] = 64'h1000; exp1[1] = 64'h1040; exp1[2] = 64'h1080; exp1[3] = 64'h10C0;

        reset = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0;
        rd_available = 1'b1; out_ready = 1'b0;
        m_base = '0; m_num = 0; m_issued = 0; m_popped = 0;
        done_seen = 0; outv_cycles = 0;
        repeat (3) tick();
        @(negedge clk);
        chki("rst_req_rd", int'(req_rd), 0);
        chk64("rst_rd_addr", rd_addr, 64'h0);
        chki("rst_out_valid", int'(out_valid), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_done", int'(done), 0);
        chki("rst_error", int'(error), 0);
        tick();
        reset = 1'b0;
        tick();

        // Basic 4-line transfer
        out_ready = 1'b1;
        start_xfer(64'h1000, 4, s);
        tick();
        @(negedge clk);
        chki("t1_busy_running", int'(busy), 1);
        chki("t1_req_rd_at_2", int'(req_rd), 1);
        wait_done(100, "t1_done");
        chki("t1_nreq", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            chk64("t1_addr_lit", addr_log[i], exp1[i]);
        if (req_cyc.size() == 4) begin
            chki("t1_first_req_latency", req_cyc[0] - s, 2);
            chki("t1_req_back_to_back", req_cyc[3] - req_cyc[0], 3);
        end
        chk64("t1_first_line_lit", first_data[63:0], 64'h1000);
        chki("t1_lines_out", m_popped, 4);
        chki("t1_done_once", done_seen, 1);
        chki("t1_busy_at_done", int'(busy_at_done), 0);

        // Back-pressure: 40 lines, consumer stalled
        out_ready = 1'b0;
        start_xfer(64'h8000, 40, s);
        repeat (60) tick();
        chki("t2_stall_nreq", addr_log.size(), DEPTH);
        @(negedge clk);
        chki("t2_out_valid_full", int'(out_valid), 1);
        tick();
        out_ready = 1'b1;
        wait_done(400, "t2_done");
        chki("t2_lines_out", m_popped, 40);
        chki("t2_model_empty", m_exp.size(), 0);
        chki("t2_nreq", addr_log.size(), 40);

        // rd_available alternating
        toggle_avail = 1'b1;
        start_xfer(64'h5010, 6, s);
        wait_done(200, "t3_done");
        toggle_avail = 1'b0;
        rd_available = 1'b1;
        chki("t3_nreq", addr_log.size(), 6);
        chki("t3_lines_out", m_popped, 6);
        if (req_cyc.size() == 6) chki("t3_req_spacing", req_cyc[5] - req_cyc[0], 10);
        tick();

        // Zero-length transfer
        start_xfer(64'h9000, 0, s);
        repeat (6) tick();
        chki("t4_done_once", done_seen, 1);
        chki("t4_done_cycle", done_cyc - s, 2);
        chki("t4_no_req", addr_log.size(), 0);
        chki("t4_no_out", outv_cycles, 0);

        // Stray response in IDLE
        inject = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chki("t5_error_set", int'(error), 1);
        chki("t5_no_out", int'(out_valid), 0);
        tick();
        start_xfer(64'h3000, 1, s);
        @(negedge clk);
        chki("t5_error_cleared", int'(error), 0);
        wait_done(100, "t5_done");
        chki("t5_lines_out", m_popped, 1);

        // Reset in the middle of a 10-line transfer
        start_xfer(64'h4000, 10, s);
        k = 0;
        while (m_popped < 5 && k < 200) begin
            tick();
            k++;
        end
        chki("t6_reached_line5", int'(m_popped >= 5), 1);
        reset = 1'b1;
        tick();
        rq.delete();
        m_exp.delete();
        reset = 1'b0;
        @(negedge clk);
        chki("t6_rst_req_rd", int'(req_rd), 0);
        chk64("t6_rst_rd_addr", rd_addr, 64'h0);
        chki("t6_rst_out_valid", int'(out_valid), 0);
        chki("t6_rst_busy", int'(busy), 0);
        chki("t6_rst_done", int'(done), 0);
        chki("t6_rst_error", int'(error), 0);
        tick();
        start_xfer(64'h2000, 2, s);
        wait_done(100, "t6_done");
        chki("t6_nreq", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            chk64("t6_addr0_lit", addr_log[0], 64'h2000);
            chk64("t6_addr1_lit", addr_log[1], 64'h2040);
        end
        chki("t6_lines_out", m_popped, 2);
        chki("t6_error_clean", int'(error), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1);
    end

endmodule
